dna_reader: RTL and testbench

- Controller that drives the FPGA device-DNA primitive (DNA_PORT) and serially reads out its 57-bit identifier.
- Generates the slow DNA clock, the READ/SHIFT strobes and DIN, and samples DOUT.
- Presents the assembled ID in parallel to the system-info register block.
- Runs from the system clock.

---
 rtl/dna_reader.sv | 109 ++++++++++
 tb/tb_dna_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_reader.sv
// rtl/dna_reader.sv - DNA_PORT controller: serially reads the device identifier and presents it in parallel
module dna_reader #(
    parameter int DnaWidth = 57,
    parameter int ClkDiv   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [DnaWidth-1:0] dna_o,
    output logic                dna_clk_o,
    output logic                dna_read_o,
    output logic                dna_shift_o,
    output logic                dna_din_o,
    input  logic                dna_dout_i
);

    localparam int PhW  = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int CntW = $clog2(DnaWidth + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t              r_state;
    logic [PhW-1:0]      r_phase;
    logic [CntW-1:0]     r_cnt;
    logic [DnaWidth-1:0] r_sr;
    logic [DnaWidth-1:0] r_dna;
    logic                r_busy;
    logic                r_valid;
    logic                r_dclk;
    logic                r_read;
    logic                r_shift;
    logic                r_din;

    logic                w_wrap;
    logic                w_last;
    logic [DnaWidth-1:0] w_sr_next;

    assign w_wrap    = (r_phase == PhW'(ClkDiv - 1));
    assign w_last    = (r_cnt == CntW'(DnaWidth - 1));
    assign w_sr_next = {r_sr[DnaWidth-2:0], dna_dout_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_dna   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dclk  <= 1'b0;
            r_read  <= 1'b0;
            r_shift <= 1'b0;
            r_din   <= 1'b0;
        end else begin
            r_din <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_read  <= 1'b1;
                        r_phase <= '0;
                        r_cnt   <= '0;
                        r_sr    <= '0;
                    end
                end
                default: begin
                    if (w_wrap) begin
                        r_phase <= '0;
                        r_dclk  <= ~r_dclk;
                        // DOUT is sampled on our falling edge, half a period after the primitive updated it
                        if (r_dclk) begin
                            r_sr  <= w_sr_next;
                            r_cnt <= r_cnt + 1'b1;
                            if (r_state == LOAD) begin
                                r_state <= SHIFT;
                                r_read  <= 1'b0;
                                r_shift <= 1'b1;
                            end
                            if (w_last) begin
                                r_state <= IDLE;
                                r_shift <= 1'b0;
                                r_dclk  <= 1'b0;
                                r_dna   <= w_sr_next;
                                r_valid <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign valid_o     = r_valid;
    assign dna_o       = r_dna;
    assign dna_clk_o   = r_dclk;
    assign dna_read_o  = r_read;
    assign dna_shift_o = r_shift;
    assign dna_din_o   = r_din;

endmodule

// File: tb/tb_dna_reader.sv
// tb/tb_dna_reader.sv - randomized model-checked bench for dna_reader at ClkDiv=1 and ClkDiv=2
module tb_dna_reader;

    localparam int W = 57;
    localparam logic [W-1:0] ID_A = 57'h1b8a94d76732894;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [W-1:0] id_val;

    always #5 clk = ~clk;

    logic         busy   [2];
    logic         valid  [2];
    logic [W-1:0] dna    [2];
    logic         dclk   [2];
    logic         dread  [2];
    logic         dshift [2];
    logic         ddin   [2];
    logic         ddout  [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            dna_reader #(.DnaWidth(W), .ClkDiv(g + 1)) u_dut (
                .clk_i       (clk),
                .rst_i       (rst),
                .start_i     (start),
                .busy_o      (busy[g]),
                .valid_o     (valid[g]),
                .dna_o       (dna[g]),
                .dna_clk_o   (dclk[g]),
                .dna_read_o  (dread[g]),
                .dna_shift_o (dshift[g]),
                .dna_din_o   (ddin[g]),
                .dna_dout_i  (ddout[g])
            );
            // DNA_PORT behaviour: READ loads the ID, SHIFT moves it toward DOUT, DOUT is the MSB
            logic [W-1:0] port_sr = '0;
            always @(posedge dclk[g]) begin
                if (dread[g])       port_sr <= id_val;
                else if (dshift[g]) port_sr <= {port_sr[W-2:0], 1'b0};
            end
            assign ddout[g] = port_sr[W-1];
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit           m_busy   [2];
    bit           m_valid  [2];
    logic [W-1:0] m_dna    [2];
    logic [W-1:0] m_pend   [2];
    int           done_at  [2];
    int           last_tog [2];
    int           n_rd     [2];
    int           n_sh     [2];
    int           n_both   [2];
    bit           done_now [2];
    logic         pclk     [2];
    logic         prd      [2];
    logic         psh      [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            done_now[i] = 1'b0;
            if (rst) begin
                m_busy[i]  = 1'b0;
                m_valid[i] = 1'b0;
                m_dna[i]   = '0;
            end else if (m_busy[i] && cyc == done_at[i]) begin
                m_busy[i]   = 1'b0;
                m_valid[i]  = 1'b1;
                m_dna[i]    = m_pend[i];
                done_now[i] = 1'b1;
            end else if (!m_busy[i] && start) begin
                m_busy[i]   = 1'b1;
                m_valid[i]  = 1'b0;
                done_at[i]  = cyc + 2 * W * (i + 1);
                m_pend[i]   = id_val;
                last_tog[i] = cyc;
                n_rd[i]     = 0;
                n_sh[i]     = 0;
                n_both[i]   = 0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("busy", 64'(busy[i]), 64'(m_busy[i]));
            chk("valid", 64'(valid[i]), 64'(m_valid[i]));
            chk("dna", 64'(dna[i]), 64'(m_dna[i]));
            chk("din", 64'(ddin[i]), 64'd0);
            if (!m_busy[i]) begin
                chk("idle_clk", 64'(dclk[i]), 64'd0);
                chk("idle_read", 64'(dread[i]), 64'd0);
                chk("idle_shift", 64'(dshift[i]), 64'd0);
            end
            if (dclk[i] !== pclk[i] && (m_busy[i] || done_now[i])) begin
                chk("clk_halfperiod", 64'(cyc - last_tog[i]), 64'(i + 1));
                last_tog[i] = cyc;
                if (dclk[i] === 1'b1) begin
                    n_rd[i]   += int'(dread[i]);
                    n_sh[i]   += int'(dshift[i]);
                    n_both[i] += int'(dread[i] & dshift[i]);
                end
            end
            if (dread[i] !== prd[i] || dshift[i] !== psh[i])
                chk("strobe_clk_low", 64'(dclk[i]), 64'd0);
            if (done_now[i]) begin
                chk("read_rises", 64'(n_rd[i]), 64'd1);
                chk("shift_rises", 64'(n_sh[i]), 64'(W - 1));
                chk("both_rises", 64'(n_both[i]), 64'd0);
            end
            pclk[i] = dclk[i];
            prd[i]  = dread[i];
            psh[i]  = dshift[i];
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((m_busy[0] || m_busy[1]) && b < 1000) begin
            tick();
            b++;
        end
        if (b >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual=timeout expected=idle cycle=%0d", cyc);
        end
    endtask

    initial begin
        int p;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_valid[i] = 0; m_dna[i] = '0;
            pclk[i] = 0; prd[i] = 0; psh[i] = 0; done_now[i] = 0;
        end
        rst    = 1'b1;
        start  = 1'b0;
        id_val = ID_A;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", 64'(busy[0]), 64'd0);
        chk("reset_valid", 64'(valid[1]), 64'd0);
        chk("reset_dna", 64'(dna[0]), 64'd0);

        // Readout with ignored starts at T+30 and T+60
        start = 1'b1;
        tick();
        start = 1'b0;
        p = cyc;
        chk("t1_busy", 64'(busy[0]), 64'd1);
        chk("t1_read", 64'(dread[1]), 64'd1);
        for (int k = 1; k < 114; k++) begin
            start = (k == 29 || k == 59);
            tick();
        end
        start = 1'b0;
        chk("t114_busy", 64'(busy[0]), 64'd1);
        chk("t114_valid", 64'(valid[0]), 64'd0);
        tick();
        chk("t115_valid", 64'(valid[0]), 64'd1);
        chk("t115_dna", 64'(dna[0]), 64'(ID_A));
        while (cyc < p + 227) tick();
        chk("t228_valid_div2", 64'(valid[1]), 64'd0);
        tick();
        chk("t229_valid_div2", 64'(valid[1]), 64'd1);
        chk("t229_dna_div2", 64'(dna[1]), 64'(ID_A));

        // Restart after completion: valid drops, old ID held until done
        id_val = 57'h1;
        pulse_start();
        chk("restart_valid", 64'(valid[0]), 64'd0);
        chk("restart_dna_held", 64'(dna[0]), 64'(ID_A));
        wait_idle();
        chk("one_dna", 64'(dna[0]), 64'd1);
        chk("one_dna_div2", 64'(dna[1]), 64'd1);

        // Reset right after the 20th sample of the ClkDiv=1 readout
        id_val = {$urandom(), $urandom()};
        pulse_start();
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_valid", 64'(valid[0]), 64'd0);
        chk("rst_dna", 64'(dna[1]), 64'd0);
        chk("rst_clk", 64'(dclk[1]), 64'd0);
        repeat (10) tick();
        pulse_start();
        wait_idle();

        id_val = '1;
        pulse_start();
        wait_idle();
        chk("ones_dna", 64'(dna[0]), 64'(57'h1ffffffffffffff));
        id_val = '0;
        pulse_start();
        wait_idle();
        chk("zero_dna", 64'(dna[1]), 64'd0);
        chk("zero_valid", 64'(valid[1]), 64'd1);

        // Random IDs with random start pulses and occasional resets
        for (int n = 0; n < 20; n++) begin
            id_val = {$urandom(), $urandom()};
            pulse_start();
            for (int k = 0; k < 260; k++) begin
                start = ($urandom_range(0, 15) == 0);
                rst   = ($urandom_range(0, 499) == 0);
                tick();
            end
            start = 1'b0;
            rst   = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 5)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
